// File: rtl/sigdecode_h_defines_pkg.sv
// Shared definitions for the ML-DSA hint-decode sequencer.
// Holds the parameter-set constants, the sequencer state encoding and the
// derived constants used when scanning the unused index-byte area.
package sigdecode_h_defines_pkg;

   localparam int MLDSA_K     = 8;
   localparam int MLDSA_OMEGA = 75;

   localparam int POLY_IDX_W = $clog2(MLDSA_K);

   // Count limit in the 8-bit width of the hint counts.
   localparam logic [7:0] OMEGA_B = 8'(MLDSA_OMEGA);

   // Word address of the last 4-byte read covering index byte OMEGA-1.
   localparam logic [6:0] PAD_LAST_PTR = 7'((MLDSA_OMEGA - 1) & ~3);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      PAD,
      RUN,
      DONE,
      ERR
   } sdh_seq_state_e;

endpackage

// File: rtl/sigdecode_h_pad_chk.sv
// Padding-byte checker for one 4-byte word of the hint index area.
// Ports:
//   word_addr_i  byte address of byte 0 of the word (multiple of 4)
//   cnt_last_i   final cumulative hint count; bytes below it are real indices
//   data_i       the word, byte 0 at the LSB
//   nonzero_o    1 when any byte in [cnt_last_i, OMEGA) is nonzero
module sigdecode_h_pad_chk
   import sigdecode_h_defines_pkg::*;
(
   input  logic [6:0]  word_addr_i,
   input  logic [7:0]  cnt_last_i,
   input  logic [31:0] data_i,
   output logic        nonzero_o
);

   logic [7:0] byte_addr;

   // Only bytes between the last used index and the end of the index area
   // belong to the padding; everything else in the word is ignored.
   always_comb begin
      nonzero_o = 1'b0;
      byte_addr = '0;
      for (int b = 0; b < 4; b++) begin
         byte_addr = {1'b0, word_addr_i} + 8'(b);
         if ((byte_addr >= cnt_last_i) && (byte_addr < OMEGA_B) &&
             (data_i[8*b +: 8] != 8'h00)) begin
            nonzero_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sigdecode_h_seq.sv
// Sequencer in front of the ML-DSA hint decoder on the signature-verify path.
// Validates the cumulative hint counts and the zero padding of the index area,
// then starts the decoder, serves per-polynomial hint sums and reports one
// done or error pulse.
// Ports:
//   clk, reset_n, zeroize      clock, sync active-low reset, sync clear
//   start_i, hint_cnt_i        start request and K cumulative counts (byte i)
//   pad_rd_en_o/ptr_o/data_i   word reads of the index-byte buffer (1-cycle latency)
//   sigdecode_h_enable_o       one-cycle decoder start
//   poly_count_i, hintsum_o    decoder polynomial index and its hint count
//   sigdecode_h_done_i         decoder idle flag
//   sigdecode_h_error_o        error level to the decoder
//   busy_o, done_o, error_o    status and completion pulses
module sigdecode_h_seq
   import sigdecode_h_defines_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 zeroize,
   input  logic                 start_i,
   input  logic [8*MLDSA_K-1:0] hint_cnt_i,
   output logic                 pad_rd_en_o,
   output logic [6:0]           pad_rd_ptr_o,
   input  logic [31:0]          pad_rd_data_i,
   output logic                 sigdecode_h_enable_o,
   input  logic [3:0]           poly_count_i,
   output logic [7:0]           hintsum_o,
   input  logic                 sigdecode_h_done_i,
   output logic                 sigdecode_h_error_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   sdh_seq_state_e state_q, state_d;

   logic [MLDSA_K-1:0][7:0] cnt_q, cnt_d;
   logic [MLDSA_K-1:0][7:0] diff_q, diff_d;
   logic [MLDSA_K-1:0][7:0] diff_calc;
   logic                    check_fail;

   logic       seen_busy_q, seen_busy_d;
   logic       rd_en_q, rd_en_d;
   logic [6:0] ptr_q, ptr_d;
   logic       chk_vld_q, chk_vld_d;
   logic [6:0] chk_addr_q, chk_addr_d;
   logic       pad_err_q, pad_err_d;
   logic       enable_q, enable_d;
   logic       done_q, done_d;
   logic       error_q, error_d;
   logic       pad_nonzero;

   // The read data returns one cycle after the request, so the check uses
   // the address captured alongside the request.
   sigdecode_h_pad_chk u_pad_chk (
      .word_addr_i (chk_addr_q),
      .cnt_last_i  (cnt_q[MLDSA_K-1]),
      .data_i      (pad_rd_data_i),
      .nonzero_o   (pad_nonzero)
   );

   // Per-polynomial hint counts and the well-formedness test on the latched
   // cumulative counts.
   always_comb begin
      diff_calc    = '0;
      check_fail   = (cnt_q[MLDSA_K-1] > OMEGA_B);
      diff_calc[0] = cnt_q[0];
      for (int i = 1; i < MLDSA_K; i++) begin
         diff_calc[i] = cnt_q[i] - cnt_q[i-1];
         if (cnt_q[i] < cnt_q[i-1]) begin
            check_fail = 1'b1;
         end
      end
   end

   // Next-state and registered-output logic. Pulse outputs are computed on
   // the transition into their state so they appear for exactly that cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      diff_d      = diff_q;
      seen_busy_d = seen_busy_q;
      rd_en_d     = 1'b0;
      ptr_d       = ptr_q;
      chk_vld_d   = rd_en_q;
      chk_addr_d  = ptr_q;
      pad_err_d   = pad_err_q;
      enable_d    = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               cnt_d   = hint_cnt_i;
               state_d = CHECK;
            end
         end
         CHECK: begin
            diff_d = diff_calc;
            if (check_fail) begin
               state_d = ERR;
               error_d = 1'b1;
            end else if (cnt_q[MLDSA_K-1] == OMEGA_B) begin
               state_d  = RUN;
               enable_d = 1'b1;
            end else begin
               state_d   = PAD;
               rd_en_d   = 1'b1;
               ptr_d     = {cnt_q[MLDSA_K-1][6:2], 2'b00};
               pad_err_d = 1'b0;
            end
         end
         PAD: begin
            if (rd_en_q && (ptr_q != PAD_LAST_PTR)) begin
               rd_en_d = 1'b1;
               ptr_d   = ptr_q + 7'd4;
            end
            if (chk_vld_q) begin
               pad_err_d = pad_err_q | pad_nonzero;
               // The decision waits for the data of the final word.
               if (chk_addr_q == PAD_LAST_PTR) begin
                  ptr_d     = '0;
                  pad_err_d = 1'b0;
                  if (pad_err_q || pad_nonzero) begin
                     state_d = ERR;
                     error_d = 1'b1;
                  end else begin
                     state_d  = RUN;
                     enable_d = 1'b1;
                  end
               end
            end
         end
         RUN: begin
            // The decoder reports done while idle, so completion only counts
            // after it has been seen busy at least once.
            if (!sigdecode_h_done_i) begin
               seen_busy_d = 1'b1;
            end
            if (seen_busy_q && sigdecode_h_done_i) begin
               seen_busy_d = 1'b0;
               state_d     = DONE;
               done_d      = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; zeroize clears everything exactly like reset.
   always_ff @(posedge clk) begin
      if (!reset_n || zeroize) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         diff_q      <= '0;
         seen_busy_q <= 1'b0;
         rd_en_q     <= 1'b0;
         ptr_q       <= '0;
         chk_vld_q   <= 1'b0;
         chk_addr_q  <= '0;
         pad_err_q   <= 1'b0;
         enable_q    <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         diff_q      <= diff_d;
         seen_busy_q <= seen_busy_d;
         rd_en_q     <= rd_en_d;
         ptr_q       <= ptr_d;
         chk_vld_q   <= chk_vld_d;
         chk_addr_q  <= chk_addr_d;
         pad_err_q   <= pad_err_d;
         enable_q    <= enable_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   // Hint sum lookup; polynomial indices beyond K read as zero.
   always_comb begin
      hintsum_o = '0;
      if (poly_count_i < 4'(MLDSA_K)) begin
         hintsum_o = diff_q[poly_count_i[POLY_IDX_W-1:0]];
      end
   end

   assign pad_rd_en_o          = rd_en_q;
   assign pad_rd_ptr_o         = ptr_q;
   assign sigdecode_h_enable_o = enable_q;
   assign sigdecode_h_error_o  = error_q;
   assign error_o              = error_q;
   assign done_o               = done_q;
   assign busy_o               = (state_q != IDLE);

endmodule

// File: tb/tb_sigdecode_h_seq.sv
// Self-checking bench for the hint-decode sequencer: directed cases for the
// count/padding rules plus randomized transactions against a reference model
// of accept/reject, read window and event timing.
module tb_sigdecode_h_seq;

   localparam int K     = 8;
   localparam int OMEGA = 75;

   logic            clk;
   logic            reset_n;
   logic            zeroize;
   logic            start_i;
   logic [8*K-1:0]  hint_cnt_i;
   logic            pad_rd_en_o;
   logic [6:0]      pad_rd_ptr_o;
   logic [31:0]     pad_rd_data_i;
   logic            sigdecode_h_enable_o;
   logic [3:0]      poly_count_i;
   logic [7:0]      hintsum_o;
   logic            sigdecode_h_done_i;
   logic            sigdecode_h_error_o;
   logic            busy_o;
   logic            done_o;
   logic            error_o;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [128];
   logic [7:0] cnt_m [K];

   int   dec_lat;
   int   dec_left;
   logic dec_done;

   sigdecode_h_seq dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .zeroize              (zeroize),
      .start_i              (start_i),
      .hint_cnt_i           (hint_cnt_i),
      .pad_rd_en_o          (pad_rd_en_o),
      .pad_rd_ptr_o         (pad_rd_ptr_o),
      .pad_rd_data_i        (pad_rd_data_i),
      .sigdecode_h_enable_o (sigdecode_h_enable_o),
      .poly_count_i         (poly_count_i),
      .hintsum_o            (hintsum_o),
      .sigdecode_h_done_i   (sigdecode_h_done_i),
      .sigdecode_h_error_o  (sigdecode_h_error_o),
      .busy_o               (busy_o),
      .done_o               (done_o),
      .error_o              (error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Index-byte buffer: one-cycle read latency, garbage when not reading.
   always @(posedge clk) begin
      if (pad_rd_en_o) begin
         pad_rd_data_i <= {mem[int'(pad_rd_ptr_o) + 3], mem[int'(pad_rd_ptr_o) + 2],
                           mem[int'(pad_rd_ptr_o) + 1], mem[int'(pad_rd_ptr_o)]};
      end else begin
         pad_rd_data_i <= $urandom;
      end
   end

   // Decoder stand-in: idle reports done, goes busy for dec_lat cycles after enable.
   always @(posedge clk) begin
      if (!reset_n || zeroize) begin
         dec_done <= 1'b1;
         dec_left <= 0;
      end else if (sigdecode_h_enable_o) begin
         dec_done <= 1'b0;
         dec_left <= dec_lat;
      end else if (dec_left > 1) begin
         dec_left <= dec_left - 1;
      end else if (dec_left == 1) begin
         dec_left <= 0;
         dec_done <= 1'b1;
      end
   end

   assign sigdecode_h_done_i = dec_done;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Bytes below lim are real indices (random nonzero), lim..OMEGA-1 are
   // zero padding, bytes past OMEGA are unrelated garbage.
   task automatic clearMem(input int lim);
      for (int a = 0; a < 128; a++) begin
         mem[a] = (a >= lim && a < OMEGA) ? 8'h00 : 8'($urandom_range(1, 255));
      end
   endtask

   task automatic applyStimulus(input int lat, input int restart_rel, input bit poke_end);
      bit         bad;
      bit         padbad;
      bit         exp_err;
      bit         finished;
      int         nreads;
      int         first_ptr;
      int         exp_rel;
      int         rd_q[$];
      int         rd_rel_q[$];
      int         rel;
      int         en_cnt, en_rel, err_cnt, err_rel, done_cnt, done_rel, rise_rel, lvl_cnt;
      int         seq_bad;
      logic       prev_dec;
      logic [7:0] dexp;

      // Reference outcome from the encoding rules.
      bad = 1'b0;
      for (int i = 1; i < K; i++) begin
         if (cnt_m[i] < cnt_m[i-1]) bad = 1'b1;
      end
      if (int'(cnt_m[K-1]) > OMEGA) bad = 1'b1;
      nreads    = 0;
      first_ptr = 0;
      padbad    = 1'b0;
      if (!bad && int'(cnt_m[K-1]) < OMEGA) begin
         first_ptr = (int'(cnt_m[K-1]) / 4) * 4;
         nreads    = ((OMEGA - 1) / 4) - int'(cnt_m[K-1]) / 4 + 1;
         for (int a = int'(cnt_m[K-1]); a < OMEGA; a++) begin
            if (mem[a] != 8'h00) padbad = 1'b1;
         end
      end
      exp_err = bad || padbad;
      exp_rel = (nreads == 0) ? 2 : nreads + 3;

      dec_lat = lat;
      for (int i = 0; i < K; i++) hint_cnt_i[8*i +: 8] = cnt_m[i];

      @(negedge clk);
      start_i  = 1'b1;
      rel      = 0;
      finished = 1'b0;
      en_cnt = 0; en_rel = 0; err_cnt = 0; err_rel = 0;
      done_cnt = 0; done_rel = 0; rise_rel = 0; lvl_cnt = 0;
      prev_dec = dec_done;
      while (!finished && rel < 300) begin
         @(negedge clk);
         rel++;
         start_i = (rel == restart_rel);
         if (pad_rd_en_o) begin
            rd_q.push_back(int'(pad_rd_ptr_o));
            rd_rel_q.push_back(rel);
         end
         if (sigdecode_h_enable_o) begin
            en_cnt++;
            en_rel = rel;
         end
         if (sigdecode_h_error_o) lvl_cnt++;
         if (dec_done && !prev_dec) rise_rel = rel;
         prev_dec = dec_done;
         if (error_o) begin
            err_cnt++;
            err_rel = rel;
         end
         if (done_o) begin
            done_cnt++;
            done_rel = rel;
         end
         if (done_o || error_o) begin
            finished = 1'b1;
            if (poke_end) start_i = 1'b1;
         end
      end

      checkOutput("completed", finished, 1);
      checkOutput("result_err", err_cnt, exp_err);
      checkOutput("result_done", done_cnt, !exp_err);
      checkOutput("nreads", rd_q.size(), nreads);
      seq_bad = 0;
      foreach (rd_q[j]) begin
         if (rd_q[j] != first_ptr + 4 * j || rd_rel_q[j] != 2 + j) seq_bad++;
      end
      checkOutput("rd_seq", seq_bad, 0);
      checkOutput("enable_cnt", en_cnt, !exp_err);
      checkOutput("err_level_cycles", lvl_cnt, exp_err);
      if (exp_err) begin
         checkOutput("err_rel", err_rel, exp_rel);
      end else begin
         checkOutput("en_rel", en_rel, exp_rel);
         checkOutput("done_after_rise", done_rel, rise_rel + 1);
      end

      @(negedge clk);
      checkOutput("idle_after", {busy_o, done_o, error_o, sigdecode_h_enable_o, pad_rd_en_o}, 0);
      start_i = 1'b0;

      for (int p = 0; p < 16; p++) begin
         poly_count_i = 4'(p);
         #1;
         dexp = (p >= K) ? 8'h00 : (p == 0) ? cnt_m[0] : cnt_m[p] - cnt_m[p-1];
         checkOutput($sformatf("hintsum_p%0d", p), hintsum_o, dexp);
      end
      poly_count_i = 4'd0;
   endtask

   initial begin
      int   total;
      int   mode;
      int   k;
      int   seen;
      int   pulses;
      logic [7:0] tmp;

      reset_n      = 1'b0;
      zeroize      = 1'b0;
      start_i      = 1'b0;
      hint_cnt_i   = '0;
      poly_count_i = 4'd3;
      dec_lat      = 4;
      clearMem(0);
      repeat (3) @(negedge clk);
      checkOutput("rst_outputs", {busy_o, done_o, error_o, sigdecode_h_enable_o,
                                  pad_rd_en_o, sigdecode_h_error_o}, 0);
      checkOutput("rst_ptr", pad_rd_ptr_o, 0);
      checkOutput("rst_hintsum", hintsum_o, 0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed: nominal padded signature");
      cnt_m = '{2, 4, 4, 9, 20, 30, 40, 60};
      clearMem(60);
      applyStimulus(5, 0, 1'b1);

      $display("[TB] directed: decreasing count");
      cnt_m = '{2, 4, 4, 3, 20, 30, 40, 60};
      clearMem(60);
      applyStimulus(5, 0, 1'b0);

      $display("[TB] directed: final count above and at limit");
      cnt_m = '{2, 4, 4, 9, 20, 30, 40, 76};
      clearMem(76);
      applyStimulus(5, 0, 1'b0);
      cnt_m = '{2, 4, 4, 9, 20, 30, 40, 75};
      clearMem(75);
      applyStimulus(3, 0, 1'b0);

      $display("[TB] directed: padding byte checks");
      cnt_m = '{2, 4, 4, 9, 20, 30, 40, 70};
      clearMem(70);
      mem[74] = 8'h05;
      applyStimulus(5, 0, 1'b0);
      clearMem(70);
      mem[75] = 8'hFF;
      applyStimulus(5, 0, 1'b0);
      cnt_m = '{2, 4, 4, 9, 20, 30, 40, 69};
      clearMem(69);
      mem[68] = 8'h11;
      applyStimulus(2, 0, 1'b0);

      $display("[TB] directed: start during pad ignored");
      cnt_m = '{1, 1, 1, 1, 1, 1, 1, 0};
      for (int i = 0; i < K; i++) hint_cnt_i[8*i +: 8] = cnt_m[i];
      cnt_m = '{2, 4, 4, 9, 20, 30, 40, 60};
      clearMem(60);
      applyStimulus(4, 3, 1'b0);

      $display("[TB] directed: zeroize during run");
      cnt_m = '{10, 20, 30, 40, 50, 60, 70, 75};
      for (int i = 0; i < K; i++) hint_cnt_i[8*i +: 8] = cnt_m[i];
      clearMem(75);
      dec_lat = 30;
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         if (sigdecode_h_enable_o) seen = 1;
         else @(negedge clk);
      end
      checkOutput("zr_enable_seen", seen, 1);
      repeat (3) @(negedge clk);
      poly_count_i = 4'd1;
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      checkOutput("zr_outputs", {busy_o, done_o, error_o, sigdecode_h_enable_o,
                                 pad_rd_en_o, sigdecode_h_error_o}, 0);
      checkOutput("zr_ptr", pad_rd_ptr_o, 0);
      checkOutput("zr_hintsum", hintsum_o, 0);
      pulses = 0;
      repeat (50) begin
         @(negedge clk);
         if (done_o || error_o || busy_o) pulses++;
      end
      checkOutput("zr_no_pulse", pulses, 0);
      poly_count_i = 4'd0;

      $display("[TB] randomized transactions");
      for (int t = 0; t < 40; t++) begin
         total = $urandom_range(0, OMEGA);
         for (int i = 0; i < K - 1; i++) cnt_m[i] = 8'($urandom_range(0, total));
         cnt_m[K-1] = 8'(total);
         for (int i = 0; i < K - 2; i++) begin
            for (int j = 0; j < K - 2 - i; j++) begin
               if (cnt_m[j] > cnt_m[j+1]) begin
                  tmp        = cnt_m[j];
                  cnt_m[j]   = cnt_m[j+1];
                  cnt_m[j+1] = tmp;
               end
            end
         end
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            k = $urandom_range(0, K - 2);
            cnt_m[k] = cnt_m[K-1] + 8'd1;
         end else if (mode == 1) begin
            cnt_m[K-1] = 8'($urandom_range(76, 255));
         end
         clearMem(int'(cnt_m[K-1]));
         if (mode >= 2 && mode <= 4) begin
            k = (int'(cnt_m[K-1]) > 4) ? int'(cnt_m[K-1]) - 4 : 0;
            mem[$urandom_range(k, 79)] = 8'($urandom_range(1, 255));
         end
         applyStimulus($urandom_range(1, 12), 0, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
